// File: rtl/lc3b_types.sv
// Shared LC-3b core types: CDB broadcast struct, ROB tag type and CDB requester count.
// No logic or latency here; no flow control.
// Consumed by cdb_arbiter and anything that snoops the CDB.
package lc3b_types;

  localparam int CDB_NUM_REQ    = 4;
  localparam int CDB_TAG_WIDTH  = 3;
  localparam int CDB_DATA_WIDTH = 16;

  typedef logic [CDB_TAG_WIDTH-1:0] lc3b_rob_addr;

  typedef struct packed {
    logic                      valid;
    lc3b_rob_addr              tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority one-hot picker: first set req bit at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none, caller masks the result.
// ptr must be below N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Offset from ptr folded back into 0..N-1 so non-power-of-two N works.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-hot same-cycle grant among result requesters, registered broadcast.
// Latency: gnt combinational, cdb_out one cycle after grant. Backpressure: requesters hold until gnt.
// CDB_ROUND_ROBIN_EN selects rotating priority; undefined gives fixed lowest-index priority.
module cdb_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_REQ    = CDB_NUM_REQ,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int TAG_WIDTH  = CDB_TAG_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   gnt,
  output cdb_t                                 cdb_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      pick_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      win_idx;
  logic               any_gnt;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  // Reset and flush both suppress the grant so no requester retires a result.
  assign gnt     = (rst_n && !flush) ? pick_gnt : '0;
  assign any_gnt = |gnt;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx = PW'(i);
      end
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
    end
  end

  assign pick_ptr = ptr;
`else
  assign pick_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_out <= '0;
    end else if (any_gnt) begin
      cdb_out.valid <= 1'b1;
      cdb_out.tag   <= req_tag[win_idx];
      cdb_out.data  <= req_data[win_idx];
    end else begin
      cdb_out.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then randomized
// handshaking traffic checked every cycle against a priority-distance model.
module tb_cdb_arbiter;
  import lc3b_types::*;

  localparam int N = 4;
`ifdef CDB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic [N-1:0]         req;
  logic [N-1:0][2:0]    req_tag;
  logic [N-1:0][15:0]   req_data;
  logic [N-1:0]         gnt;
  cdb_t                 cdb_out;

  int vectors;
  int miscompares;

  cdb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .req      (req),
    .req_tag  (req_tag),
    .req_data (req_data),
    .gnt      (gnt),
    .cdb_out  (cdb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Winner = requesting index with the smallest rotational distance from the pointer.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = RR ? ((i - p + N) % N) : i;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  int          m_ptr;
  logic        m_valid;
  logic [2:0]  m_tag;
  logic [15:0] m_data;
  logic [N-1:0] last_gnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_tag   <= '0;
      m_data  <= '0;
      m_ptr   <= 0;
    end else if (!flush && model_pick(req, m_ptr) >= 0) begin
      m_valid <= 1'b1;
      m_tag   <= req_tag[model_pick(req, m_ptr)];
      m_data  <= req_data[model_pick(req, m_ptr)];
      m_ptr   <= (model_pick(req, m_ptr) + 1) % N;
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_g;
    int w;
    w = model_pick(req, m_ptr);
    exp_g = (!rst_n || flush || w < 0) ? '0 : N'(1 << w);
    check("gnt", 32'(gnt), 32'(exp_g));
    check("cdb_valid", 32'(cdb_out.valid), 32'(m_valid));
    check("cdb_tag", 32'(cdb_out.tag), 32'(m_tag));
    check("cdb_data", 32'(cdb_out.data), 32'(m_data));
    last_gnt = gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_seq;
    logic [2:0]   exp_tag;
    vectors     = 0;
    miscompares = 0;
    last_gnt    = '0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    req      = '0;
    req_tag  = '0;
    req_data = '0;

    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(cdb_out.valid), 32'h0);
    check("rst_tag", 32'(cdb_out.tag), 32'h0);
    check("rst_data", 32'(cdb_out.data), 32'h0);
    step();
    rst_n = 1'b1;

    // Single requester 2.
    step();
    req = 4'b0100; req_tag[2] = 3'd5; req_data[2] = 16'h1234;
    #1 check("single_gnt", 32'(gnt), 32'h4);
    step();
    req = 4'b0000;
    #1;
    check("single_valid", 32'(cdb_out.valid), 32'h1);
    check("single_tag", 32'(cdb_out.tag), 32'h5);
    check("single_data", 32'(cdb_out.data), 32'h1234);
    check("idle_gnt", 32'(gnt), 32'h0);

    // Pointer sits at 3 in the rotating build; requesters 0 and 1 both pending.
    step();
    req = 4'b0011;
    req_tag[0] = 3'd1; req_data[0] = 16'hAAAA;
    req_tag[1] = 3'd2; req_data[1] = 16'hBBBB;
    #1 check("wrap_gnt0", 32'(gnt), 32'h1);
    step();
    req_data[0] = 16'hCCCC;
    #1 check("wrap_gnt1", 32'(gnt), RR ? 32'h2 : 32'h1);
    step();
    req = 4'b0000;
    #1;
    check("wrap_tag", 32'(cdb_out.tag), RR ? 32'h2 : 32'h1);
    check("wrap_data", 32'(cdb_out.data), RR ? 32'hBBBB : 32'hCCCC);

    // Asynchronous reset mid-cycle with everyone requesting.
    step();
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = 3'(i + 1);
      req_data[i] = 16'h1000 + 16'(i);
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_valid", 32'(cdb_out.valid), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_seq = RR ? N'(1 << (k % N)) : 4'b0001;
      exp_tag = RR ? 3'((k % N) + 1) : 3'd1;
      check("rr_gnt", 32'(gnt), 32'(exp_seq));
      step();
      #1;
      check("rr_valid", 32'(cdb_out.valid), 32'h1);
      check("rr_tag", 32'(cdb_out.tag), 32'(exp_tag));
    end

    // Flush suppresses the grant and the next broadcast.
    step();
    req = 4'b0010; flush = 1'b1;
    #1 check("flush_gnt", 32'(gnt), 32'h0);
    step();
    flush = 1'b0;
    #1;
    check("flush_valid", 32'(cdb_out.valid), 32'h0);
    check("post_flush_gnt", 32'(gnt), 32'h2);

    // Two non-adjacent requesters held for three cycles.
    step();
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1 check("fixed_gnt", 32'(gnt), RR ? ((k % 2 == 1) ? 32'h2 : 32'h8) : 32'h2);
      step();
    end
    req = 4'b0000;

    // Randomized traffic obeying the hold-until-granted handshake.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!rst_n) begin
        rst_n = 1'b1;
      end
      flush = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_gnt[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            req[i] = 1'b0;
          end else begin
            req_tag[i]  = 3'($urandom);
            req_data[i] = 16'($urandom);
          end
        end else if (!req[i] && $urandom_range(0, 9) < 4) begin
          req[i]      = 1'b1;
          req_tag[i]  = 3'($urandom);
          req_data[i] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (ALU stations 0-2, load buffer 3).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, result width.
REQ-003 SHALL have parameter TAG_WIDTH, default 3, ROB tag width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  mispredict flush, synchronous.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester result-ready.
REQ-008 SHALL have port req_tag  input  NUM_REQ x TAG_WIDTH  ROB entry of each result.
REQ-009 SHALL have port req_data  input  NUM_REQ x DATA_WIDTH  result value.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant, combinational, same cycle.
REQ-011 SHALL have port cdb_out  output  CDB struct (valid 1, tag TAG_WIDTH, data DATA_WIDTH)  registered bus broadcast.

Function
REQ-012 SHALL assert at most one gnt bit per cycle; gnt[i] only when req[i]=1.
REQ-013 SHALL grant some requester whenever any req bit is 1 and flush=0 (work-conserving).
REQ-014 SHALL drive no grant while flush=1.
REQ-015 SHALL, at the edge after a grant to i, load cdb_out = {valid=1, tag=req_tag[i], data=req_data[i]}; latency exactly 1 cycle.
REQ-016 SHALL load cdb_out.valid=0 (tag, data held) on any edge with no grant.
REQ-017 SHALL clear cdb_out.valid at the edge where flush=1, overriding any pending grant.
REQ-018 Requester handshake: requester SHALL hold req, tag, data stable until it sees gnt; on gnt it drops req next cycle or presents a new result; arbiter imposes no timing beyond this.
REQ-019 SHALL keep a priority pointer ptr (log2 NUM_REQ bits); search order ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-020 SHALL update ptr to (granted index + 1) mod NUM_REQ on each grant; unchanged when no grant; wrap from NUM_REQ-1 to 0.
REQ-021 SHALL leave ptr unchanged when flush=1.
REQ-022 Single requester SHALL be granted every cycle it requests (no bubble).

Reset
REQ-023 SHALL, on rst_n=0, immediately set cdb_out.valid=0, cdb_out.tag=0, cdb_out.data=0, ptr=0, independent of clk.
REQ-024 SHALL drive gnt=0 while rst_n=0.
REQ-025 SHALL resume arbitration on the first edge after rst_n deasserts, starting at requester 0; a reset mid-broadcast discards it.

Configuration
REQ-026 Macro CDB_ROUND_ROBIN_EN defined: arbitration per REQ-019..REQ-021.
REQ-027 Macro CDB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins, ptr register absent; all other requirements unchanged.

Structure
REQ-028 CDB struct, lc3b_rob_addr and constant CDB_NUM_REQ=4 SHALL live in shared package lc3b_types; no new package.
REQ-029 SHALL contain one sub-module rr_pick (rotate-priority one-hot picker: req vector + ptr in, one-hot out, purely combinational); registers stay in cdb_arbiter.

Verification
REQ-030 Reset: rst_n=0 asynchronously mid-cycle with req=4'b1111 -> cdb_out.valid=0, gnt=0 immediately; after release first grant = 4'b0001.
REQ-031 Single: req=4'b0100, tag=5, data=16'h1234 -> gnt=4'b0100 same cycle; next cycle cdb_out={1,5,16'h1234}.
REQ-032 Round-robin: req=4'b1111 held 8 cycles from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; cdb valid every cycle.
REQ-033 Wrap/skip: ptr=3, req=4'b0011 -> gnt=4'b0001 then 4'b0010; ptr becomes 1 then 2.
REQ-034 Flush: req=4'b0010 with flush=1 -> gnt=0, next cdb_out.valid=0, ptr unchanged; flush=0 next cycle -> gnt=4'b0010.
REQ-035 Fixed-priority build (macro off): req=4'b1010 held 3 cycles -> gnt=4'b0010 every cycle.
